seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Parametrised, time-multiplexed 7-segment display driver: captures N_DIG packed display codes into a snapshot register, scans them one digit at a time onto a shared active-low segment bus, and drives active-low one-hot digit enables. It replaces the one-digit mux-plus-decoder pair with a registered, free-running scanner that adds a scan prescaler, an anti-ghosting dead slot, a frame strobe and snapshot loading, and it sits between the datapath's status registers and the board's segment/anode pins.

## Interface
- N_DIG, 4: number of digits scanned; legal range is 2..16.
- CODE_W, 4: bits per digit code; legal range is 1..4; codes are zero-extended to 4 bits before decoding.
- DIV, 50000: clock cycles per digit slot; minimum is 2.
- clk  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- en  in  1  scan enable.
- load  in  1  snapshot strobe; codes are sampled on the edge where load=1.
- codes  in  N_DIG*CODE_W  digit i occupies bits [i*CODE_W +: CODE_W].
- seg  out  7  active-low segments; seg[0]=a … seg[6]=g.
- an  out  N_DIG  active-low one-hot digit enable.
- digit_idx  out  max(1,$clog2(N_DIG))  index of the digit currently scanned (pre register).
- frame  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

## Operation
- State: snap[N_DIG*CODE_W], prescaler pre (0..DIV-1), idx (0..N_DIG-1), output registers seg/an/frame.
- Reset values: snap=0, pre=0, idx=0, seg=7'b1111111, an=all ones, frame=0, digit_idx=0.
- Snapshot: when load=1, snap<=codes, independent of en. When load=0, snap holds.
- Scan, en=1: pre increments each cycle. When pre==DIV-1, pre<=0 and idx<=(idx==N_DIG-1)?0:idx+1. On the idx N_DIG-1→0 transition, frame<=1 for exactly one cycle.
- Scan, en=0: pre and idx hold, frame<=0, an<=all ones, seg<=7'b1111111.
- Output register update, en=1:
  - an<=~(1<<idx), except an<=all ones when pre==0 (dead cycle per slot).
  - seg<=hex(snap digit idx), or 7'b1111111 during the dead cycle.
- Decoding is active-low hex. Required codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous load and digit advance on the same edge: both take effect, and the next slot uses the new snap.
- codes changing without load has no effect on the display.
- Reset asserted mid-scan clears all state and outputs immediately, without waiting for clk.

## Timing
- seg, an and frame are registered. Each reflects the pre/idx/snap values present before the edge, so it lags those state values by one cycle.
- load at edge k: snap updates at k, and seg shows the new code at edge k+1 if that digit is being scanned.
- Each digit slot lasts DIV cycles: 1 dead cycle (all off) followed by DIV-1 lit cycles. A full frame lasts N_DIG*DIV cycles.
- en rising: scanning resumes from the held pre/idx, and outputs respond one cycle later.
- en falling: outputs are blanked one cycle later.

## Configuration
- SEG7_BLANK_EN defined:
  - Adds input blank[N_DIG-1:0], which is captured into a blank snapshot on load alongside codes.
  - A digit whose captured blank bit is 1 produces an=all ones and seg=7'b1111111 for its entire slot.
  - Scan timing and frame are unchanged.
- SEG7_BLANK_EN undefined: no blank port exists, and every digit is displayed.

## Test plan
- Reset: hold resetn=0 with en=1 and toggle clk → seg=7F, an=F, frame=0, digit_idx=0. Assert resetn=0 mid-slot → all outputs clear with no clock edge.
- Scan order (N_DIG=4, CODE_W=4, DIV=4): load codes=16'h3210, then en=1.
  - Each slot gives 1 cycle of an=F/seg=7F, then 3 cycles of an=E with seg=1000000.
  - Then an=D with seg=1111001, an=B with seg=0100100, an=7 with seg=0110000.
  - frame pulses once per 16 cycles, on the idx 3→0 edge.
- Snapshot isolation: change codes to 16'hFFFF without load → display unchanged. Pulse load → digit 0 shows 0001110 in its next lit cycle.
- Load/advance collision: assert load on the same edge pre wraps 3→0 → the new slot's lit cycles use the new code. No cycle shows a stale code.
- Enable gating: drop en mid-slot → an=F and seg=7F one cycle later, with pre/idx held. Raise en → scanning resumes at the same digit with the remaining slot length.
- CODE_W=2, N_DIG=2: load codes=4'b1011 → digit 0 shows 0110000 (code 3) and digit 1 shows 0100100 (code 2). With SEG7_BLANK_EN and blank=2'b10 → digit 1 slot is fully dark.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux
//
// Time-multiplexed 7-segment display driver. A load strobe captures N_DIG
// packed digit codes into a snapshot register. A free-running scanner then
// puts one digit at a time onto a shared active-low segment bus and drives
// the matching active-low digit enable.
//
// Each digit slot lasts DIV clock cycles. The first cycle of every slot is a
// dead cycle with all digits off, which stops the previous digit from ghosting
// onto the next one. frame pulses for one cycle on the wrap from the last
// digit back to digit 0.
//
// Optional feature macro: SEG7_BLANK_EN
//   When defined, the module gains a per-digit blank input. It is captured
//   on load together with codes. A blanked digit stays dark for its whole
//   slot, and scan timing is unchanged.
//
// Parameters
//   N_DIG   digits scanned (2..16)
//   CODE_W  bits per digit code (1..4); codes are zero-extended to 4 bits
//   DIV     clock cycles per digit slot (>= 2)
//
// Ports
//   clk        in   single clock, rising edge
//   resetn     in   asynchronous active-low reset
//   en         in   scan enable; when low, pre/idx hold and outputs blank
//   load       in   snapshot strobe; codes are sampled on the edge where
//                   load=1
//   codes      in   N_DIG*CODE_W; digit i is at [i*CODE_W +: CODE_W]
//   blank      in   N_DIG (only when SEG7_BLANK_EN is defined)
//   seg        out  active-low segments, seg[0]=a ... seg[6]=g (registered)
//   an         out  active-low one-hot digit enable (registered)
//   digit_idx  out  index of the digit currently scanned (scan state)
//   frame      out  one-cycle pulse on the last-to-first digit wrap
//                   (registered)
// ---------------------------------------------------------------------------
module seg7_scan_mux #(
    parameter int N_DIG  = 4,
    parameter int CODE_W = 4,
    parameter int DIV    = 50000
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   en,
    input  logic                                   load,
    input  logic [N_DIG*CODE_W-1:0]                codes,
`ifdef SEG7_BLANK_EN
    input  logic [N_DIG-1:0]                       blank,
`endif
    output logic [6:0]                             seg,
    output logic [N_DIG-1:0]                       an,
    output logic [((N_DIG > 1) ? $clog2(N_DIG) : 1)-1:0] digit_idx,
    output logic                                   frame
);

    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIG - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    // Active-low hex decode, seg[0]=a ... seg[6]=g.
    function automatic logic [6:0] hex_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // State registers
    logic [N_DIG*CODE_W-1:0] snap_q, snap_d;
    logic [PRE_W-1:0]        pre_q,  pre_d;
    logic [IDX_W-1:0]        idx_q,  idx_d;
    logic [6:0]              seg_q,  seg_d;
    logic [N_DIG-1:0]        an_q,   an_d;
    logic                    frame_q, frame_d;
`ifdef SEG7_BLANK_EN
    logic [N_DIG-1:0]        blank_q, blank_d;
`endif

    // Unpack the snapshot so the scanned digit can be selected by index.
    logic [CODE_W-1:0] digit_code [N_DIG];
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_unpack
        assign digit_code[gi] = snap_q[gi*CODE_W +: CODE_W];
    end

    logic [3:0] cur_code;
    logic       dark;

    always_comb begin
        snap_d   = snap_q;
        pre_d    = pre_q;
        idx_d    = idx_q;
        seg_d    = SEG_OFF;
        an_d     = '1;
        frame_d  = 1'b0;
        cur_code = 4'(digit_code[idx_q]);
        // The first cycle of every slot is dead, which prevents ghosting.
        dark     = (pre_q == '0);
`ifdef SEG7_BLANK_EN
        blank_d  = blank_q;
        dark     = dark || blank_q[idx_q];
`endif

        // The snapshot is loaded whether or not the scan is enabled.
        if (load) begin
            snap_d = codes;
`ifdef SEG7_BLANK_EN
            blank_d = blank;
`endif
        end

        if (en) begin
            if (pre_q == LAST_PRE) begin
                pre_d   = '0;
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                frame_d = (idx_q == LAST_IDX);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end

            // Outputs follow the state before this edge. A load on the same
            // edge as a digit advance takes effect at the next slot's first
            // lit cycle, because that cycle is always preceded by a dead one.
            if (!dark) begin
                an_d  = ~(N_DIG'(1) << idx_q);
                seg_d = hex_decode(cur_code);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snap_q  <= '0;
            pre_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= '1;
            frame_q <= 1'b0;
`ifdef SEG7_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            snap_q  <= snap_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
`ifdef SEG7_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign frame     = frame_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_mux
//
// Directed testbench for seg7_scan_mux with N_DIG=4, CODE_W=4, DIV=4.
// For each clock edge, the driver updates a small reference model of the
// display. It then pushes the expected {seg, an, frame, digit_idx} word into
// exp_q. An independent monitor pops one word on every falling edge and
// compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_seg7_scan_mux;

    localparam int N_DIG  = 4;
    localparam int CODE_W = 4;
    localparam int DIV    = 4;
    localparam int W      = 7 + 4 + 1 + 2;

    // Clock and reset
    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        en     = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] codes  = 16'h0000;
`ifdef SEG7_BLANK_EN
    logic [3:0]  blank  = 4'b0000;
`endif
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame;

    always #5 clk = ~clk;

    seg7_scan_mux #(.N_DIG(N_DIG), .CODE_W(CODE_W), .DIV(DIV)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .load      (load),
        .codes     (codes),
`ifdef SEG7_BLANK_EN
        .blank     (blank),
`endif
        .seg       (seg),
        .an        (an),
        .digit_idx (digit_idx),
        .frame     (frame)
    );

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;

    // Required active-low hex patterns, indexed by code 0..F.
    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference display state
    logic [3:0] m_snap [4];
    int m_pre = 0;
    int m_idx = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_snap[i] = 4'h0;
        m_pre = 0;
        m_idx = 0;
    endtask

    // Advance the model by one rising edge, using the current inputs, and
    // queue the outputs that the DUT must show after that edge.
    task automatic model_edge();
        logic [6:0] es;
        logic [3:0] ea;
        logic       ef;
        es = 7'b1111111;
        ea = 4'hF;
        ef = 1'b0;
        if (!resetn) begin
            model_reset();
        end else begin
            if (en) begin
                ef = (m_pre == DIV - 1) && (m_idx == N_DIG - 1);
                if (m_pre != 0) begin
                    ea = ~(4'b0001 << m_idx);
                    es = hex_tab[m_snap[m_idx]];
                end
                if (m_pre == DIV - 1) begin
                    m_pre = 0;
                    m_idx = (m_idx == N_DIG - 1) ? 0 : m_idx + 1;
                end else begin
                    m_pre = m_pre + 1;
                end
            end
            if (load) begin
                for (int i = 0; i < 4; i++) m_snap[i] = codes[i*4 +: 4];
            end
        end
        exp_q.push_back({es, ea, ef, 2'(m_idx)});
    endtask

    // Driver: called at a falling edge. It applies the inputs, lets one rising
    // edge happen, and returns at the next falling edge.
    task automatic step(input logic e, input logic l, input logic [15:0] c);
        en    = e;
        load  = l;
        codes = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [15:0] c);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, c);
    endtask

    // Scan with en=1 until the model prescaler reaches the target value.
    task automatic run_to_pre(input int target, input logic [15:0] c);
        for (int k = 0; k <= DIV && m_pre != target; k++) step(1'b1, 1'b0, c);
    endtask

    task automatic check_now(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Monitor: compares one registered output word per clock.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_out++;
            n_cmp++;
            if ({seg, an, frame, digit_idx} !== e) begin
                n_bad++;
                $display("FAIL scan_out #%0d: got seg=%b an=%h frame=%b idx=%0d, want seg=%b an=%h frame=%b idx=%0d",
                         n_out, seg, an, frame, digit_idx, e[13:7], e[6:3], e[2], e[1:0]);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] sweep [4] = '{16'h7654, 16'hBA98, 16'hFEDC, 16'h3210};

    initial begin
        model_reset();
        // Reset held with en=1 while the clock toggles.
        resetn = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'h0000);
        resetn = 1'b1;

        // Load 3210 while the scan is disabled, then run one full frame plus
        // part of the next one.
        step(1'b0, 1'b1, 16'h3210);
        run(20, 16'h3210);

        // Codes change without load, which must not change the display.
        run(8, 16'hFFFF);
        step(1'b1, 1'b1, 16'hFFFF);
        run(16, 16'hFFFF);

        // Load on the edge where the prescaler wraps, for each code set.
        for (int s = 0; s < 4; s++) begin
            run_to_pre(DIV - 1, sweep[s]);
            step(1'b1, 1'b1, sweep[s]);
            run(16, sweep[s]);
        end

        // Drop en in the middle of a slot, then resume the scan.
        run_to_pre(2, 16'h3210);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'h3210);
        run(10, 16'h3210);

        // Assert reset asynchronously during a lit cycle.
        run_to_pre(2, 16'h3210);
        #1;
        resetn = 1'b0;
        #1;
        check_now("async_rst_seg", {9'h0, seg}, 16'h007F);
        check_now("async_rst_an", {12'h0, an}, 16'h000F);
        check_now("async_rst_frame", {15'h0, frame}, 16'h0000);
        check_now("async_rst_idx", {14'h0, digit_idx}, 16'h0000);
        model_reset();
        for (int k = 0; k < 2; k++) step(1'b1, 1'b0, 16'h3210);
        resetn = 1'b1;
        // The snapshot was cleared, so every digit shows 0 until a new load.
        run(8, 16'h3210);

        #1;
        check_now("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
